// File: rtl/app_mul_seq_accum_pkg.sv
// Shared types and width helpers for the sequential radix-4 multiply-accumulate block.
package app_mul_seq_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int steps_of(input int width_b);
        return width_b / 32'sd2;
    endfunction

    // Step counter needs at least one bit even for a single-step multiplier.
    function automatic int step_cnt_w(input int width_b);
        int steps;
        steps = width_b / 32'sd2;
        return (steps <= 32'sd1) ? 32'sd1 : $clog2(steps);
    endfunction

    function automatic int prod_w(input int width_a, input int width_b);
        return width_a + width_b;
    endfunction

endpackage

// File: rtl/app_mul_seq_accum_ctrl.sv
// Sequencer for the multiply: IDLE/RUN/DONE state, radix-4 step counter and handshakes.
module app_mul_seq_ctrl #(
    parameter int STEPS = 4,
    parameter int CW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          out_ready,
    output logic          in_ready,
    output logic          out_valid,
    output logic          lay_last,
    output logic          capture,
    output logic          run,
    output logic          last_step,
    output logic [CW-1:0] step_k
);
    import app_mul_seq_accum_pkg::*;

    localparam logic [CW-1:0] K_LAST = CW'(STEPS - 1);
    localparam logic [CW-1:0] K_PEN  = CW'(STEPS - 2);

    state_e        state_q;
    logic [CW-1:0] k_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          lay_last_q;

    // State machine with registered handshake and last-digit outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            lay_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        state_q    <= ST_RUN;
                        k_q        <= '0;
                        in_ready_q <= 1'b0;
                        lay_last_q <= (STEPS == 1);
                    end
                end
                ST_RUN: begin
                    if (k_q == K_LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        lay_last_q  <= 1'b0;
                    end else begin
                        k_q        <= k_q + CW'(1);
                        lay_last_q <= (k_q == K_PEN);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    k_q         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    lay_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign lay_last  = lay_last_q;
    assign step_k    = k_q;
    assign capture   = (state_q == ST_IDLE) & in_valid;
    assign run       = (state_q == ST_RUN);
    assign last_step = (state_q == ST_RUN) & (k_q == K_LAST);

endmodule

// File: rtl/app_mul_seq_accum.sv
// Iterative signed multiplier: feeds an external 2-bit layer one radix-4 digit of B per
// cycle and shift-accumulates the returned partial sums into the product.
module app_mul_seq_accum #(
    parameter int WIDTH_A = 8,
    parameter int WIDTH_B = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH_A-1:0]         a_in,
    input  logic [WIDTH_B-1:0]         b_in,
    output logic [WIDTH_A-1:0]         lay_a,
    output logic                       lay_b_low,
    output logic                       lay_b_high,
    output logic                       lay_cin,
    output logic                       lay_last,
    input  logic signed [WIDTH_A+1:0]  layer_sum,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH_A+WIDTH_B-1:0] product
);
    import app_mul_seq_accum_pkg::*;

    localparam int STEPS = steps_of(WIDTH_B);
    localparam int CW    = step_cnt_w(WIDTH_B);
    localparam int PW    = prod_w(WIDTH_A, WIDTH_B);

    logic          capture_s;
    logic          run_s;
    logic          last_s;
    logic [CW-1:0] step_k_s;

    app_mul_seq_ctrl #(
        .STEPS (STEPS),
        .CW    (CW)
    ) u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .lay_last  (lay_last),
        .capture   (capture_s),
        .run       (run_s),
        .last_step (last_s),
        .step_k    (step_k_s)
    );

    logic [WIDTH_A-1:0] a_q, a_d;
    logic [WIDTH_B-1:0] b_rest_q, b_rest_d;
    logic               dig_lo_q, dig_lo_d;
    logic               dig_hi_q, dig_hi_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      prod_q, prod_d;
    logic signed [PW-1:0] lsum_ext_s;
    logic signed [PW-1:0] term_s;

    // Digit registers hold the current radix-4 digit; b_rest_q holds digits still to come.
    always_comb begin
        a_d        = a_q;
        b_rest_d   = b_rest_q;
        dig_lo_d   = dig_lo_q;
        dig_hi_d   = dig_hi_q;
        acc_d      = acc_q;
        prod_d     = prod_q;
        lsum_ext_s = PW'(layer_sum);
        term_s     = lsum_ext_s <<< {step_k_s, 1'b0};
        if (capture_s) begin
            a_d      = a_in;
            dig_lo_d = b_in[0];
            dig_hi_d = b_in[1];
            b_rest_d = b_in >> 2'd2;
            acc_d    = '0;
        end else if (run_s) begin
            acc_d = acc_q + $unsigned(term_s);
            if (last_s) begin
                prod_d   = acc_d;
                dig_lo_d = 1'b0;
                dig_hi_d = 1'b0;
            end else begin
                dig_lo_d = b_rest_q[0];
                dig_hi_d = b_rest_q[1];
                b_rest_d = b_rest_q >> 2'd2;
            end
        end else begin
            acc_d = acc_q;
        end
    end

    // Operand, digit, accumulator and product registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_rest_q <= '0;
            dig_lo_q <= 1'b0;
            dig_hi_q <= 1'b0;
            acc_q    <= '0;
            prod_q   <= '0;
        end else begin
            a_q      <= a_d;
            b_rest_q <= b_rest_d;
            dig_lo_q <= dig_lo_d;
            dig_hi_q <= dig_hi_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
        end
    end

    assign lay_a      = a_q;
    assign lay_b_low  = dig_lo_q;
    assign lay_b_high = dig_hi_q;
    assign lay_cin    = lay_last & dig_hi_q;
    assign product    = prod_q;

endmodule

// File: tb/tb_app_mul_seq_accum.sv
// Bench for app_mul_seq_accum: 8x8 and 8x2 instances, exact layer model, scoreboard of A*B.
module tb_app_mul_seq_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst8_n, iv8, ir8, lo8, hi8, cin8, last8, ov8, or8;
    logic [7:0]  a8, b8, la8;
    logic [9:0]  ls8;
    logic [15:0] p8;

    logic        rst2_n, iv2, ir2, lo2, hi2, cin2, last2, ov2, or2;
    logic [7:0]  a2, la2;
    logic [1:0]  b2;
    logic [9:0]  ls2;
    logic [9:0]  p2;

    int     n_pass  = 0;
    int     n_total = 0;
    longint q8[$];
    longint q2[$];
    int     lat;

    function automatic logic [9:0] layer_fn(input logic [7:0] a, input logic lo,
                                            input logic hi, input logic last);
        int d;
        d = last ? (int'(lo) - 2 * int'(hi)) : (int'(lo) + 2 * int'(hi));
        return 10'(int'($signed(a)) * d);
    endfunction

    assign ls8 = layer_fn(la8, lo8, hi8, last8);
    assign ls2 = layer_fn(la2, lo2, hi2, last2);

    app_mul_seq_accum #(.WIDTH_A(8), .WIDTH_B(8)) u_dut8 (
        .clk(clk), .rst_n(rst8_n), .in_valid(iv8), .in_ready(ir8), .a_in(a8), .b_in(b8),
        .lay_a(la8), .lay_b_low(lo8), .lay_b_high(hi8), .lay_cin(cin8), .lay_last(last8),
        .layer_sum(ls8), .out_valid(ov8), .out_ready(or8), .product(p8)
    );

    app_mul_seq_accum #(.WIDTH_A(8), .WIDTH_B(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .in_valid(iv2), .in_ready(ir2), .a_in(a2), .b_in(b2),
        .lay_a(la2), .lay_b_low(lo2), .lay_b_high(hi2), .lay_cin(cin2), .lay_last(last2),
        .layer_sum(ls2), .out_valid(ov2), .out_ready(or2), .product(p2)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard for the 8x8 instance: push A*B on accept, compare on product handshake.
    always @(negedge clk) begin
        if (rst8_n) begin
            check("cin8", cin8, last8 & hi8);
            check("excl8", ir8 & ov8, 0);
            if (iv8 && ir8) q8.push_back(longint'($signed(a8)) * longint'($signed(b8)));
            if (ov8 && or8) begin
                if (q8.size() == 0) begin
                    n_total++;
                    $display("FAIL sb8: product %0d with no pending operation", $signed(p8));
                end else begin
                    check("prod8", $signed(p8), q8.pop_front());
                end
            end
        end
    end

    always @(negedge rst8_n) q8.delete();

    // Scoreboard for the single-step 8x2 instance.
    always @(negedge clk) begin
        if (rst2_n) begin
            check("cin2", cin2, last2 & hi2);
            check("excl2", ir2 & ov2, 0);
            if (iv2 && ir2) q2.push_back(longint'($signed(a2)) * longint'($signed(b2)));
            if (ov2 && or2) begin
                if (q2.size() == 0) begin
                    n_total++;
                    $display("FAIL sb2: product %0d with no pending operation", $signed(p2));
                end else begin
                    check("prod2", $signed(p2), q2.pop_front());
                end
            end
        end
    end

    always @(negedge rst2_n) q2.delete();

    task automatic start8(input logic [7:0] a, input logic [7:0] b);
        logic hs;
        hs  = 1'b0;
        a8  = a;
        b8  = b;
        iv8 = 1'b1;
        for (int i = 0; i < 50 && !hs; i++) begin
            hs = ir8;
            cyc();
        end
        iv8 = 1'b0;
        if (!hs) begin
            n_total++;
            $display("FAIL start8: in_ready never seen, got 0, expected 1");
        end
    endtask

    task automatic wait_valid8(output int l);
        l = 1;
        while (!ov8 && l < 50) begin
            cyc();
            l++;
        end
        if (!ov8) begin
            n_total++;
            $display("FAIL wait_valid8: out_valid timeout, got 0, expected 1");
        end
    endtask

    logic [7:0] t2_a [3] = '{8'h80, 8'hFF, 8'h7F};
    logic [7:0] t2_b [3] = '{8'h80, 8'h7F, 8'h80};
    longint     t2_e [3] = '{64'sd16384, -64'sd127, -64'sd16256};

    initial begin
        rst8_n = 1'b0; iv8 = 1'b0; or8 = 1'b1; a8 = '0; b8 = '0;
        rst2_n = 1'b0; iv2 = 1'b0; or2 = 1'b1; a2 = '0; b2 = '0;
        repeat (3) cyc();
        check("rst_in_ready", ir8, 1);
        check("rst_out_valid", ov8, 0);
        check("rst_product", p8, 0);
        check("rst_lay", {la8, lo8, hi8, cin8, last8}, 0);
        check("rst_in_ready2", ir2, 1);
        rst8_n = 1'b1;
        rst2_n = 1'b1;
        cyc();

        // 3 x 5: digit timing and latency
        start8(8'd3, 8'd5);
        for (int c = 1; c <= 5; c++) begin
            check("t1_valid", ov8, c == 5);
            check("t1_last", last8, c == 4);
            if (c == 5) check("t1_prod", $signed(p8), 15);
            else cyc();
        end
        cyc();
        check("t1_ready_after", ir8, 1);

        // extreme operands
        for (int i = 0; i < 3; i++) begin
            start8(t2_a[i], t2_b[i]);
            wait_valid8(lat);
            check("t2_latency", lat, 5);
            check("t2_prod", $signed(p8), t2_e[i]);
            cyc();
        end

        // consumer back-pressure: 11 x -6
        or8 = 1'b0;
        start8(8'd11, 8'hFA);
        wait_valid8(lat);
        for (int i = 0; i < 5; i++) begin
            check("t3_valid_held", ov8, 1);
            check("t3_in_ready_low", ir8, 0);
            check("t3_prod_held", $signed(p8), -66);
            cyc();
        end
        or8 = 1'b1;
        cyc();
        check("t3_released", ov8, 0);
        check("t3_ready_back", ir8, 1);

        // in_valid during RUN must be ignored
        start8(8'd2, 8'd3);
        a8 = 8'd9; b8 = 8'd9; iv8 = 1'b1;
        cyc();
        cyc();
        iv8 = 1'b0;
        wait_valid8(lat);
        check("t4_prod", $signed(p8), 6);
        repeat (3) cyc();
        check("t4_no_second", ov8, 0);
        check("t4_queue", q8.size(), 0);

        // reset in the middle of RUN
        start8(8'd5, 8'd7);
        cyc();
        cyc();
        rst8_n = 1'b0;
        #1;
        check("t5_out_valid", ov8, 0);
        check("t5_in_ready", ir8, 1);
        check("t5_product", p8, 0);
        check("t5_lay", {la8, lo8, hi8, last8}, 0);
        #1;
        rst8_n = 1'b1;
        cyc();
        start8(8'hF9, 8'd6);
        wait_valid8(lat);
        check("t5_prod", $signed(p8), -42);
        cyc();

        // single-step multiplier: -5 x -2
        a2 = 8'hFB; b2 = 2'b10; iv2 = 1'b1;
        cyc();
        iv2 = 1'b0;
        check("w2_last", last2, 1);
        check("w2_valid_early", ov2, 0);
        cyc();
        check("w2_valid", ov2, 1);
        check("w2_prod", $signed(p2), 10);
        cyc();

        // randomized traffic on both instances
        fork
            for (int i = 0; i < 12000; i++) begin
                iv8 = 1'($urandom_range(0, 1));
                a8  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                b8  = ($urandom_range(0, 7) == 0) ? 8'h80 : 8'($urandom);
                or8 = ($urandom_range(0, 3) != 0);
                cyc();
            end
            for (int j = 0; j < 12000; j++) begin
                iv2 = 1'($urandom_range(0, 1));
                a2  = 8'($urandom);
                b2  = 2'($urandom);
                or2 = ($urandom_range(0, 3) != 0);
                cyc();
            end
        join
        iv8 = 1'b0; or8 = 1'b1;
        iv2 = 1'b0; or2 = 1'b1;
        repeat (20) cyc();
        check("drain8", q8.size(), 0);
        check("drain2", q2.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
